// File: rtl/vending_pkg.sv
// Shared coin codes and buffer sizing for the coin_acceptor / vending_machine pair.
//   COIN_NONE / COIN_5 / COIN_10 : codes carried on coin[1:0] into vending_machine.in
//   FIFO_DEPTH                   : entries held between debounce and the coin output
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam int unsigned FIFO_DEPTH = 2;

    // Per-denomination flag pair, laid out to match the reject port bit order.
    typedef struct packed {
        logic dime;
        logic nickel;
    } coin_pair_t;

endpackage : vending_pkg

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw coin sensor.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   raw        : asynchronous, possibly bouncing sensor level
//   event_rise : one-cycle pulse when the debounced level goes 0 -> 1
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic event_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_flip;

    // The flip fires on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    assign w_diff = (r_sync2 != r_stable);
    assign w_flip = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchroniser, disagreement counter and stable level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                // Only a rising stable level counts as a coin.
                r_rise   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign event_rise = r_rise;

endmodule : coin_debounce

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces both sensors, buffers accepted coins in a
// 2-entry FIFO and emits one registered coin code per cycle.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low
//   sens_5    : raw nickel sensor
//   sens_10   : raw dime sensor
//   accept_en : 1 = new coins are buffered, 0 = new coins are returned
//   hold      : 1 = downstream busy, no pop, coin forced to none
//   coin      : registered coin code, one cycle per coin
//   reject    : one-cycle return pulse, bit0 nickel, bit1 dime
//   level     : buffer occupancy 0..2
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_5,
    input  logic       sens_10,
    input  logic       accept_en,
    input  logic       hold,
    output logic [1:0] coin,
    output logic [1:0] reject,
    output logic [1:0] level
);

    logic       w_ev5;
    logic       w_ev10;

    logic [1:0] r_mem [FIFO_DEPTH];
    logic       r_head;
    logic [1:0] r_level;
    logic [1:0] r_coin;
    logic [1:0] r_reject;

    logic [1:0] w_mem_nxt [FIFO_DEPTH];
    logic       w_head_nxt;
    logic [1:0] w_level_nxt;
    logic [1:0] w_coin_nxt;
    coin_pair_t w_rej;
    logic       w_pop;
    logic [1:0] w_free;
    logic       w_take5;
    logic       w_take10;
    logic       w_tail;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_5 (
        .clk        (clk),
        .reset      (reset),
        .raw        (sens_5),
        .event_rise (w_ev5)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_10 (
        .clk        (clk),
        .reset      (reset),
        .raw        (sens_10),
        .event_rise (w_ev10)
    );

    // Pop, enqueue arbitration and next buffer contents.
    always_comb begin
        w_mem_nxt = r_mem;
        w_rej     = '0;

        w_pop      = !hold && (r_level != 2'd0);
        w_coin_nxt = w_pop ? r_mem[r_head] : COIN_NONE;

        // A same-cycle pop frees its slot for an incoming coin.
        w_free = 2'(FIFO_DEPTH) - r_level + 2'(w_pop);

        // Nickel wins the first free slot; dime needs one more.
        w_take5  = w_ev5  && accept_en && (w_free != 2'd0);
        w_take10 = w_ev10 && accept_en && (w_free > 2'(w_take5));

        w_rej.nickel = w_ev5  && !w_take5;
        w_rej.dime   = w_ev10 && !w_take10;

        // Tail = head + level (mod 2); when full it aliases the head being popped.
        w_tail = r_head ^ r_level[0];
        if (w_take5) begin
            w_mem_nxt[w_tail] = COIN_5;
        end
        if (w_take10) begin
            w_mem_nxt[w_tail ^ w_take5] = COIN_10;
        end

        w_head_nxt  = r_head ^ w_pop;
        w_level_nxt = r_level - 2'(w_pop) + 2'(w_take5) + 2'(w_take10);
    end

    // Buffer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= COIN_NONE;
            end
            r_head   <= 1'b0;
            r_level  <= 2'd0;
            r_coin   <= COIN_NONE;
            r_reject <= 2'b00;
        end else begin
            r_mem    <= w_mem_nxt;
            r_head   <= w_head_nxt;
            r_level  <= w_level_nxt;
            r_coin   <= w_coin_nxt;
            r_reject <= w_rej;
        end
    end

    assign coin   = r_coin;
    assign reject = r_reject;
    assign level  = r_level;

endmodule : coin_acceptor

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_coin_acceptor;

    localparam int DEB = 4;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       sens_5    = 1'b0;
    logic       sens_10   = 1'b0;
    logic       accept_en = 1'b1;
    logic       hold      = 1'b0;
    logic [1:0] coin;
    logic [1:0] reject;
    logic [1:0] level;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sens_5    (sens_5),
        .sens_10   (sens_10),
        .accept_en (accept_en),
        .hold      (hold),
        .coin      (coin),
        .reject    (reject),
        .level     (level)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw sample history (index 2 = what the design sees after synchronisation),
    // debounced level, length of the current disagreement run, pending events,
    // and the coin buffer as a plain queue.
    int h5[$];
    int h10[$];
    int st5, st10, run5, run10;
    bit ev5, ev10;
    int q[$];
    int e_coin, e_rej, e_level;
    bit m_pop;

    task automatic model_clear();
        h5  = '{0, 0, 0};
        h10 = '{0, 0, 0};
        st5 = 0; st10 = 0; run5 = 0; run10 = 0;
        ev5 = 1'b0; ev10 = 1'b0;
        q.delete();
        e_coin = 0; e_rej = 0; e_level = 0;
    endtask

    // Level flips after DEB consecutive samples disagreeing with it; a 0->1 flip is a coin.
    task automatic deb_step(input int s, inout int st, inout int run, output bit ev);
        ev = 1'b0;
        if (s != st) begin
            run++;
            if (run == DEB) begin
                st  = s;
                run = 0;
                ev  = (s == 1);
            end
        end else begin
            run = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else begin
            m_pop  = !hold && (q.size() > 0);
            e_coin = m_pop ? q.pop_front() : 0;
            e_rej  = 0;
            if (ev5) begin
                if (accept_en && q.size() < 2) q.push_back(1);
                else e_rej |= 1;
            end
            if (ev10) begin
                if (accept_en && q.size() < 2) q.push_back(2);
                else e_rej |= 2;
            end
            e_level = q.size();
            h5.push_front(int'(sens_5));
            void'(h5.pop_back());
            h10.push_front(int'(sens_10));
            void'(h10.pop_back());
            deb_step(h5[2], st5, run5, ev5);
            deb_step(h10[2], st10, run10, ev10);
        end
    end

    // ---------------- per-cycle compare and tallies ----------------
    int n5, n10, nrej5, nrej10;
    int seq_code[$];
    int seq_cyc[$];
    int cyc = 0;

    task automatic clear_tally();
        n5 = 0; n10 = 0; nrej5 = 0; nrej10 = 0;
        seq_code.delete();
        seq_cyc.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_val("coin", int'(coin), e_coin);
        check_val("reject", int'(reject), e_rej);
        check_val("level", int'(level), e_level);
        if (coin == 2'b01) n5++;
        if (coin == 2'b10) n10++;
        if (reject[0]) nrej5++;
        if (reject[1]) nrej10++;
        if (coin != 2'b00) begin
            seq_code.push_back(int'(coin));
            seq_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise sens_5 (already at a negedge) and measure edges until the coin appears.
    task automatic measure_nickel(output int lat);
        lat = -1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (coin == 2'b01 && lat < 0) lat = i - 1;
        end
    endtask

    int lat;

    initial begin
        model_clear();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);

        // 1: clean nickel, latency and single pulse
        clear_tally();
        sens_5 = 1'b1;
        measure_nickel(lat);
        sens_5 = 1'b0;
        idle(8);
        check_val("t1_latency", lat, DEB + 3);
        check_val("t1_nickels", n5, 1);
        check_val("t1_rejects", nrej5 + nrej10, 0);
        check_val("t1_level", int'(level), 0);

        // 2: bouncing dime then steady high
        clear_tally();
        for (int i = 0; i < 6; i++) begin
            sens_10 = (i % 2 == 0);
            step();
        end
        sens_10 = 1'b1;
        idle(8);
        sens_10 = 1'b0;
        idle(10);
        check_val("t2_dimes", n10, 1);
        check_val("t2_rejects", nrej5 + nrej10, 0);

        // 3: too-short pulse
        clear_tally();
        sens_5 = 1'b1;
        idle(3);
        sens_5 = 1'b0;
        idle(10);
        check_val("t3_coins", n5 + n10, 0);
        check_val("t3_rejects", nrej5 + nrej10, 0);

        // 4: both sensors together, nickel first then dime next cycle
        clear_tally();
        sens_5 = 1'b1; sens_10 = 1'b1;
        idle(10);
        sens_5 = 1'b0; sens_10 = 1'b0;
        idle(10);
        check_val("t4_count", seq_code.size(), 2);
        if (seq_code.size() == 2) begin
            check_val("t4_first", seq_code[0], 1);
            check_val("t4_second", seq_code[1], 2);
            check_val("t4_gap", seq_cyc[1] - seq_cyc[0], 1);
        end

        // 5: hold with three nickels -> overflow reject, then drain
        clear_tally();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sens_5 = 1'b1;
            idle(5);
            sens_5 = 1'b0;
            idle(5);
        end
        idle(4);
        check_val("t5_level_full", int'(level), 2);
        check_val("t5_nickel_rej", nrej5, 1);
        check_val("t5_coins_held", n5 + n10, 0);
        clear_tally();
        hold = 1'b0;
        idle(4);
        check_val("t5_drained", seq_code.size(), 2);
        if (seq_code.size() == 2) begin
            check_val("t5_first", seq_code[0], 1);
            check_val("t5_second", seq_code[1], 1);
            check_val("t5_gap", seq_cyc[1] - seq_cyc[0], 1);
        end

        // 6: acceptance disabled
        clear_tally();
        accept_en = 1'b0;
        sens_10 = 1'b1;
        idle(8);
        sens_10 = 1'b0;
        idle(8);
        accept_en = 1'b1;
        check_val("t6_dime_rej", nrej10, 1);
        check_val("t6_coins", n5 + n10, 0);

        // 7: reset in the middle of debounce with a coin already buffered
        hold = 1'b1;
        sens_5 = 1'b1;
        idle(8);
        sens_5 = 1'b0;
        idle(6);
        check_val("t7_pre_level", int'(level), 1);
        sens_5 = 1'b1;
        idle(3);
        reset = 1'b0;
        #1;
        check_val("t7_rst_coin", int'(coin), 0);
        check_val("t7_rst_reject", int'(reject), 0);
        check_val("t7_rst_level", int'(level), 0);
        idle(2);
        hold = 1'b0;
        clear_tally();
        reset = 1'b1;
        measure_nickel(lat);
        sens_5 = 1'b0;
        idle(8);
        check_val("t7_latency", lat, DEB + 3);
        check_val("t7_nickels", n5, 1);

        // Random traffic against the model.
        for (int s = 0; s < 400; s++) begin
            sens_5    = ($urandom_range(0, 1) == 1);
            sens_10   = ($urandom_range(0, 1) == 1);
            accept_en = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 2) == 0);
            idle(int'($urandom_range(1, 8)));
        end
        sens_5 = 1'b0; sens_10 = 1'b0; hold = 1'b0; accept_en = 1'b1;
        idle(12);
        check_val("final_level", int'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_coin_acceptor
